// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: target end of the CPU load/store interface.
// One word request is accepted at a time over a valid/ready handshake, the access is
// performed LATENCY cycles after acceptance, and a response is returned over a second
// valid/ready handshake.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-low reset; clears state and all storage
//   req_valid   request present
//   req_ready   responder idle and able to accept a request
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   resp_valid  response present
//   resp_ready  requester consumes the response
//   resp_rdata  load data; 0 for stores and errors
//   resp_err    request was misaligned or out of range
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned AW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            req_err_q, req_err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            mem_we;

  logic [31:0] mem [DEPTH];

  // Handshake outputs decode the registered state only.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    req_err_d  = req_err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d   = StBusy;
          cnt_d     = CntLoad;
          write_d   = req_write;
          idx_d     = req_addr[AW+1:2];
          wdata_d   = req_wdata;
          // No aliasing: any bit above the word index marks the request out of range.
          req_err_d = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d    = StResp;
          resp_err_d = req_err_q;
          rdata_d    = '0;
          if (!req_err_q) begin
            if (write_q) begin
              mem_we = 1'b1;
            end else begin
              rdata_d = mem[idx_q];
            end
          end
        end
      end
      StResp: begin
        // rdata deliberately keeps its value after the handshake.
        if (resp_ready) begin
          state_d    = StIdle;
          resp_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      req_err_q  <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[AW'(i)] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      req_err_q  <= req_err_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
      if (mem_we) begin
        mem[idx_q] <= wdata_q;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the CPU's load/store interface.
- Accepts one word request at a time over a valid/ready handshake and performs the read or write after a fixed LATENCY.
- Returns a response (read data or write ack, plus error flag) over a second valid/ready handshake.
- Replaces the zero-latency DataMemory for the multi-cycle CPU; the CPU stalls on req_ready/resp_valid.

Parameters:
- DEPTH, 256, number of 32-bit words in storage; power of two, >= 2
- LATENCY, 4, cycles from request acceptance to response valid; >= 1
- AW, 8, word-index width; must equal log2(DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store (sw), 0 = load (lw)
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester consumes response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset: reset==0 sampled at posedge clk (synchronous, active-low).
  - Next state IDLE; counter 0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - All DEPTH words cleared to 0.
  - Any in-flight request is aborted; no write is committed.
- States: IDLE, BUSY, RESP. req_ready = (state==IDLE), decoded from the registered state only; no combinational path from inputs.
- IDLE: at a posedge with req_valid & req_ready:
  - Latch write, addr, wdata.
  - Compute err = (addr[1:0]!=0) | (addr[31:AW+2]!=0).
  - Load counter = LATENCY-1; go to BUSY.
  - Without req_valid, stay in IDLE.
- BUSY: request inputs are ignored.
  - Counter decrements at each posedge while nonzero.
  - At the posedge where counter==0, commit the access and go to RESP.
  - Read, no err: resp_rdata <= mem[addr[AW+1:2]].
  - Write, no err: mem[addr[AW+1:2]] <= wdata; resp_rdata <= 0.
  - err: no memory change; resp_rdata <= 0.
  - In all cases resp_err <= err and resp_valid <= 1.
- Latency: a request accepted at edge t0 has resp_valid high starting at edge t0+LATENCY. With LATENCY=1, valid follows in the next cycle.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until a posedge with resp_ready=1.
  - At that edge: resp_valid <= 0, resp_err <= 0, go to IDLE. resp_rdata holds its value.
  - req_ready=0 throughout RESP; only one transaction is outstanding.
  - A new request is accepted no earlier than the edge after the response handshake, so the minimum request period is LATENCY+2 cycles.
- Ordering: a committed write is visible to any later-accepted read.
- Errors: an erroring request still takes the full LATENCY and completes through the normal handshake. The responder never hangs.
- Address wrap: none. Any address at or above DEPTH*4 bytes is an error, not aliased.
- Simultaneous events: reset==0 overrides every handshake in the same cycle. resp_ready while not in RESP has no effect.

Test Plan:
- Reset, hold reset=0 for 2 cycles then release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Reading 0x0 returns 0x00000000.
- Write 0xDEADBEEF to 0x10 with LATENCY=4, accepted at edge 0, resp_ready=1 -> resp_valid rises at edge 4, resp_err=0, rdata=0, req_ready=1 again after edge 5. A following read of 0x10 returns 0xDEADBEEF.
- Read 0x10 with resp_ready held 0 for 3 cycles after valid, and req_valid=1 with addr 0x20 meanwhile -> resp_valid stays 1, rdata stays 0xDEADBEEF, req_ready=0, and the 0x20 request is not accepted until after the handshake.
- Write 0x1234 to 0x13 (misaligned), then to 0x400 (out of range for DEPTH=256) -> each responds after 4 cycles with resp_err=1, rdata=0. Reads of 0x10 and 0x0 are unchanged.
- Write 0xCAFEF00D to 0x20 and assert reset=0 at the second BUSY cycle -> at the next edge state is IDLE, resp_valid=0. After release, a read of 0x20 returns 0.
- resp_ready tied 1, req_valid tied 1, reads of 0x0, 0x4, 0x8 -> accepts at edges 0, 6, 12; resp_valid at edges 4, 10, 16, each high exactly one cycle.
